fetch_exec_sequencer: RTL and testbench

//  Parametrised control-step sequencer; successor to hand-sequenced T0..T3 stimulus.

---
 rtl/fetch_exec_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_fetch_exec_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_exec_sequencer.sv
// Control-step sequencer for Datapath_P2: fetch T0-T2, per-opcode execute T3-T7, memory stalls.
// Define SEQ_SINGLE_STEP_EN to pause after every instruction until a step_in pulse.
module fetch_exec_sequencer #(
  parameter int IR_W = 32,
  parameter int OPC_W = 5,
  parameter int STEP_W = 4,
  parameter logic [OPC_W-1:0] OPC_ADD = OPC_W'(5'b00011)
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              run_in,
  input  logic              step_in,
  input  logic [IR_W-1:0]   IR,
  input  logic              CON_FF,
  input  logic              mem_ready,
  output logic [22:0]       ctrl,
  output logic [OPC_W-1:0]  alu_op,
  output logic [STEP_W-1:0] step_cnt,
  output logic              run,
  output logic              illegal_op
);

  localparam logic [22:0] PC_OUT   = 23'd1 << 0;
  localparam logic [22:0] Z_LOW    = 23'd1 << 2;
  localparam logic [22:0] MDR_OUT  = 23'd1 << 3;
  localparam logic [22:0] IN_PORT  = 23'd1 << 4;
  localparam logic [22:0] C_OUT    = 23'd1 << 5;
  localparam logic [22:0] BA_OUT   = 23'd1 << 6;
  localparam logic [22:0] R_OUT    = 23'd1 << 7;
  localparam logic [22:0] MAR_IN   = 23'd1 << 8;
  localparam logic [22:0] Z_IN     = 23'd1 << 9;
  localparam logic [22:0] PC_IN    = 23'd1 << 10;
  localparam logic [22:0] MDR_IN   = 23'd1 << 11;
  localparam logic [22:0] IR_IN    = 23'd1 << 12;
  localparam logic [22:0] Y_IN     = 23'd1 << 13;
  localparam logic [22:0] OUT_PORT = 23'd1 << 14;
  localparam logic [22:0] R_IN     = 23'd1 << 15;
  localparam logic [22:0] CON_IN   = 23'd1 << 16;
  localparam logic [22:0] INC_PC   = 23'd1 << 17;
  localparam logic [22:0] READ     = 23'd1 << 18;
  localparam logic [22:0] WRITE    = 23'd1 << 19;
  localparam logic [22:0] GRA      = 23'd1 << 20;
  localparam logic [22:0] GRB      = 23'd1 << 21;
  localparam logic [22:0] GRC      = 23'd1 << 22;

  localparam logic [22:0] FETCH_T0 = PC_OUT | MAR_IN | INC_PC | Z_IN;

  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01100);
  localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(5'b10010);
  localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(5'b10011);
  localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(5'b10101);
  localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(5'b10110);
  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(5'b11001);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11010);

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [1:0] {S_IDLE, S_STEP, S_HALT, S_PAUSE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_STEP, S_HALT} state_t;
`endif

  state_t           state;
  logic [2:0]       step;
  logic [2:0]       nxt_step;
  logic [OPC_W-1:0] opc_q;
  logic [OPC_W-1:0] ir_opc;
  logic [OPC_W-1:0] cur_opc;
  logic             stall;
  logic             unused_bits;

  function automatic logic is_alu(input logic [OPC_W-1:0] opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
  endfunction

  function automatic logic is_legal(input logic [OPC_W-1:0] opc);
    return is_alu(opc) || (opc == OP_ADDI) || (opc == OP_LD) || (opc == OP_ST) ||
           (opc == OP_BR) || (opc == OP_JR) || (opc == OP_IN) || (opc == OP_OUT) ||
           (opc == OP_NOP) || (opc == OP_HALT);
  endfunction

  // Illegal opcodes behave like a one-step execute that drives nothing.
  function automatic logic is_last(input logic [2:0] s, input logic [OPC_W-1:0] opc);
    logic last;
    last = 1'b0;
    case (s)
      3'd2: last = (opc == OP_NOP);
      3'd3: last = (opc == OP_JR) || (opc == OP_IN) || (opc == OP_OUT) ||
                   (opc == OP_HALT) || !is_legal(opc);
      3'd5: last = is_alu(opc) || (opc == OP_ADDI);
      3'd6: last = (opc == OP_BR);
      3'd7: last = (opc == OP_LD) || (opc == OP_ST);
      default: last = 1'b0;
    endcase
    return last;
  endfunction

  function automatic logic [22:0] step_ctrl(input logic [2:0] s, input logic [OPC_W-1:0] opc,
                                            input logic con);
    logic [22:0] c;
    c = '0;
    if (s == 3'd0) c = FETCH_T0;
    else if (s == 3'd1) c = Z_LOW | PC_IN | READ | MDR_IN;
    else if (s == 3'd2) c = MDR_OUT | IR_IN;
    else if (is_alu(opc) || opc == OP_ADDI) begin
      case (s)
        3'd3: c = GRB | R_OUT | Y_IN;
        3'd4: c = (opc == OP_ADDI) ? (C_OUT | Z_IN) : (GRC | R_OUT | Z_IN);
        3'd5: c = Z_LOW | GRA | R_IN;
        default: c = '0;
      endcase
    end else if (opc == OP_LD || opc == OP_ST) begin
      case (s)
        3'd3: c = GRB | BA_OUT | Y_IN;
        3'd4: c = C_OUT | Z_IN;
        3'd5: c = Z_LOW | MAR_IN;
        3'd6: c = (opc == OP_LD) ? (READ | MDR_IN) : (GRA | R_OUT | MDR_IN);
        3'd7: c = (opc == OP_LD) ? (MDR_OUT | GRA | R_IN) : WRITE;
        default: c = '0;
      endcase
    end else if (opc == OP_BR) begin
      case (s)
        3'd3: c = GRA | R_OUT | CON_IN;
        3'd4: c = PC_OUT | Y_IN;
        3'd5: c = C_OUT | Z_IN;
        3'd6: c = con ? (Z_LOW | PC_IN) : '0;
        default: c = '0;
      endcase
    end else if (s == 3'd3) begin
      case (opc)
        OP_JR:   c = GRA | R_OUT | PC_IN;
        OP_IN:   c = IN_PORT | GRA | R_IN;
        OP_OUT:  c = GRA | R_OUT | OUT_PORT;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  assign ir_opc   = IR[IR_W-1 -: OPC_W];
  assign nxt_step = step + 3'd1;
  assign step_cnt = STEP_W'(step);

`ifdef SEQ_SINGLE_STEP_EN
  assign unused_bits = ^IR[IR_W-OPC_W-1:0];
`else
  assign unused_bits = ^{IR[IR_W-OPC_W-1:0], step_in};
`endif

  // The opcode is taken live from IR only on the T2->T3 edge; later steps use the latched copy.
  always_comb begin
    cur_opc = (step == 3'd2) ? ir_opc : opc_q;
    stall   = ((ctrl & (READ | WRITE)) != '0) && !mem_ready;
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state      <= S_IDLE;
      step       <= 3'd0;
      opc_q      <= '0;
      ctrl       <= '0;
      alu_op     <= OPC_ADD;
      run        <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run_in) begin
            state  <= S_STEP;
            run    <= 1'b1;
            step   <= 3'd0;
            ctrl   <= FETCH_T0;
            alu_op <= OPC_ADD;
          end
        end
        S_STEP: begin
          if (!stall) begin
            if (step == 3'd2) opc_q <= ir_opc;
            if (is_last(step, cur_opc)) begin
              step   <= 3'd0;
              alu_op <= OPC_ADD;
              if (cur_opc == OP_HALT) begin
                state <= S_HALT;
                run   <= 1'b0;
                ctrl  <= '0;
              end else begin
`ifdef SEQ_SINGLE_STEP_EN
                state <= S_PAUSE;
                ctrl  <= '0;
`else
                ctrl  <= FETCH_T0;
`endif
              end
            end else begin
              step       <= nxt_step;
              ctrl       <= step_ctrl(nxt_step, cur_opc, CON_FF);
              alu_op     <= (nxt_step == 3'd4 && is_alu(cur_opc)) ? cur_opc : OPC_ADD;
              illegal_op <= (nxt_step == 3'd3) && !is_legal(cur_opc);
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (step_in) begin
            state <= S_STEP;
            step  <= 3'd0;
            ctrl  <= FETCH_T0;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          run   <= 1'b0;
          ctrl  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Random-instruction bench for fetch_exec_sequencer with a step-table reference model and scoreboard.
module tb_fetch_exec_sequencer;

  localparam logic [22:0] PCOUT = 23'h000001, ZLOW = 23'h000004, MDROUT = 23'h000008;
  localparam logic [22:0] INPORT = 23'h000010, COUT = 23'h000020, BAOUT = 23'h000040;
  localparam logic [22:0] ROUT = 23'h000080, MARIN = 23'h000100, ZIN = 23'h000200;
  localparam logic [22:0] PCIN = 23'h000400, MDRIN = 23'h000800, IRIN = 23'h001000;
  localparam logic [22:0] YIN = 23'h002000, OUTPORT = 23'h004000, RIN = 23'h008000;
  localparam logic [22:0] CONIN = 23'h010000, INCPC = 23'h020000, RD = 23'h040000;
  localparam logic [22:0] WR = 23'h080000, GA = 23'h100000, GB = 23'h200000, GC = 23'h400000;
  localparam logic [4:0] ADDC = 5'b00011, HALTC = 5'b11010;
  localparam logic [4:0] LEGAL [12] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12,
                                       5'd18, 5'd19, 5'd21, 5'd22, 5'd25};

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        run_in = 1'b0;
  logic        step_in = 1'b0;
  logic [31:0] IR = '0;
  logic        CON_FF = 1'b0;
  logic        mem_ready = 1'b1;
  logic [22:0] ctrl;
  logic [4:0]  alu_op;
  logic [3:0]  step_cnt;
  logic        run;
  logic        illegal_op;

  typedef struct packed {
    logic [3:0]  step;
    logic [22:0] ctrl;
    logic [4:0]  alu;
    logic        ill;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        e;
  logic [22:0] plan_ctrl[$];
  logic [4:0]  plan_alu[$];
  bit          plan_ill[$];
  int          checks = 0;
  int          errors = 0;

  always #5 Clock = ~Clock;

  fetch_exec_sequencer dut (
    .Clock(Clock), .Clear(Clear), .run_in(run_in), .step_in(step_in), .IR(IR),
    .CON_FF(CON_FF), .mem_ready(mem_ready), .ctrl(ctrl), .alu_op(alu_op),
    .step_cnt(step_cnt), .run(run), .illegal_op(illegal_op)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void push_step(input logic [22:0] c, input logic [4:0] a, input bit ill);
    plan_ctrl.push_back(c);
    plan_alu.push_back(a);
    plan_ill.push_back(ill);
  endfunction

  // Reference: the instruction as an ordered list of control words, one per T-step.
  task automatic plan_instr(input logic [4:0] opc, input bit con);
    plan_ctrl.delete();
    plan_alu.delete();
    plan_ill.delete();
    push_step(PCOUT | MARIN | INCPC | ZIN, ADDC, 0);
    push_step(ZLOW | PCIN | RD | MDRIN, ADDC, 0);
    push_step(MDROUT | IRIN, ADDC, 0);
    case (opc)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        push_step(GB | ROUT | YIN, ADDC, 0);
        push_step(GC | ROUT | ZIN, opc, 0);
        push_step(ZLOW | GA | RIN, ADDC, 0);
      end
      5'd12: begin
        push_step(GB | ROUT | YIN, ADDC, 0);
        push_step(COUT | ZIN, ADDC, 0);
        push_step(ZLOW | GA | RIN, ADDC, 0);
      end
      5'd0, 5'd2: begin
        push_step(GB | BAOUT | YIN, ADDC, 0);
        push_step(COUT | ZIN, ADDC, 0);
        push_step(ZLOW | MARIN, ADDC, 0);
        push_step((opc == 5'd0) ? (RD | MDRIN) : (GA | ROUT | MDRIN), ADDC, 0);
        push_step((opc == 5'd0) ? (MDROUT | GA | RIN) : WR, ADDC, 0);
      end
      5'd18: begin
        push_step(GA | ROUT | CONIN, ADDC, 0);
        push_step(PCOUT | YIN, ADDC, 0);
        push_step(COUT | ZIN, ADDC, 0);
        push_step(con ? (ZLOW | PCIN) : 23'h0, ADDC, 0);
      end
      5'd19: push_step(GA | ROUT | PCIN, ADDC, 0);
      5'd21: push_step(INPORT | GA | RIN, ADDC, 0);
      5'd22: push_step(GA | ROUT | OUTPORT, ADDC, 0);
      5'd25: ;
      5'd26: push_step(23'h0, ADDC, 0);
      default: push_step(23'h0, ADDC, 1);
    endcase
  endtask

  function automatic bit known_opc(input logic [4:0] o);
    foreach (LEGAL[i]) if (LEGAL[i] == o) return 1;
    return (o == HALTC);
  endfunction

  function automatic logic [4:0] pick_opc();
    logic [4:0] o;
    if ($urandom_range(0, 5) == 0) begin
      do o = 5'($urandom); while (known_opc(o));
    end else begin
      o = LEGAL[$urandom_range(0, 11)];
    end
    return o;
  endfunction

  // Called at the falling edge inside T0; leaves off at the falling edge of the next T0 (or HALT).
  // t6_stall < 0 randomises every memory stall; otherwise only T6 stalls, by that many cycles.
  task automatic applyStimulus(input logic [31:0] ir, input bit con, input int t6_stall,
                               input bit abort);
    logic [4:0] opc;
    bit         mr_q[$];
    rec_t       r;
    int         ns;
    int         last_idx;
    opc = ir[31:27];
    plan_instr(opc, con);
    last_idx = abort ? 3 : plan_ctrl.size() - 1;
    for (int i = 0; i <= last_idx; i++) begin
      ns = 0;
      if ((plan_ctrl[i] & (RD | WR)) != 0)
        ns = (t6_stall < 0) ? $urandom_range(0, 2) : ((i == 6) ? t6_stall : 0);
      for (int k = 0; k <= ns; k++) begin
        r.step = 4'(i);
        r.ctrl = plan_ctrl[i];
        r.alu  = plan_alu[i];
        r.ill  = plan_ill[i];
        exp_q.push_back(r);
        mr_q.push_back(((plan_ctrl[i] & (RD | WR)) != 0) ? (k == ns) : 1'($urandom));
      end
    end
`ifdef SEQ_SINGLE_STEP_EN
    if (!abort && opc != HALTC) begin
      r = '{step: 4'd0, ctrl: 23'h0, alu: ADDC, ill: 1'b0};
      exp_q.push_back(r);
      exp_q.push_back(r);
    end
`endif
    for (int j = 0; j < mr_q.size(); j++) begin
      if (j > 0) @(negedge Clock);
      if (j == 0) begin
        IR = ir;
        CON_FF = con;
      end
      mem_ready = mr_q[j];
      run_in = 1'($urandom);
      step_in = 1'($urandom);
    end
    if (abort) begin
      @(posedge Clock);
      #2 Clear = 1'b0;
      run_in = 1'b0;
      #1;
      checkOutput("abort_ctrl", 32'(ctrl), 32'h0);
      checkOutput("abort_run", 32'(run), 32'h0);
      checkOutput("abort_step", 32'(step_cnt), 32'h0);
      checkOutput("abort_alu", 32'(alu_op), 32'(ADDC));
      return;
    end
    @(negedge Clock);
    run_in = 1'b0;
    step_in = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    if (opc != HALTC) begin
      @(negedge Clock);
      step_in = 1'b1;
      @(negedge Clock);
      step_in = 1'b0;
    end
`endif
  endtask

  // Scoreboard monitor: every cycle the sequencer reports run=1 must match the next expected step.
  always @(negedge Clock) begin
    #1;
    if (run === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_step: got step %0d ctrl %h, expected no activity",
                 step_cnt, ctrl);
      end else begin
        e = exp_q.pop_front();
        checkOutput("step_cnt", 32'(step_cnt), 32'(e.step));
        checkOutput("ctrl", 32'(ctrl), 32'(e.ctrl));
        checkOutput("alu_op", 32'(alu_op), 32'(e.alu));
        checkOutput("illegal_op", 32'(illegal_op), 32'(e.ill));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d expected steps pending",
             exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge Clock);
    #1;
    checkOutput("reset_ctrl", 32'(ctrl), 32'h0);
    checkOutput("reset_alu", 32'(alu_op), 32'(ADDC));
    checkOutput("reset_step", 32'(step_cnt), 32'h0);
    checkOutput("reset_run", 32'(run), 32'h0);
    checkOutput("reset_illegal", 32'(illegal_op), 32'h0);
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    #1;
    checkOutput("idle_run", 32'(run), 32'h0);
    run_in = 1'b1;
    @(negedge Clock);

    applyStimulus(32'h9880_0000, 1'b0, 0, 1'b0);
    applyStimulus({5'b00011, 4'd2, 4'd3, 4'd4, 15'd0}, 1'b0, 0, 1'b0);
    applyStimulus({5'b00000, 27'h0123456}, 1'b0, 3, 1'b0);
    applyStimulus({5'b10010, 27'h0}, 1'b0, 0, 1'b0);
    applyStimulus({5'b10010, 27'h0}, 1'b1, 0, 1'b0);
    applyStimulus({5'b11111, 27'h0}, 1'b0, 0, 1'b0);
    applyStimulus({5'b00010, 27'h0}, 1'b1, 0, 1'b0);
    for (int n = 0; n < 40; n++)
      applyStimulus({pick_opc(), 27'($urandom)}, 1'($urandom), -1, 1'b0);
    applyStimulus({HALTC, 27'h0}, 1'b0, 0, 1'b0);

    for (int n = 0; n < 4; n++) begin
      #1;
      checkOutput("halt_run", 32'(run), 32'h0);
      checkOutput("halt_ctrl", 32'(ctrl), 32'h0);
      run_in = 1'b1;
      step_in = 1'($urandom);
      @(negedge Clock);
    end
    checkOutput("halt_queue", 32'(exp_q.size()), 32'h0);

    Clear = 1'b0;
    run_in = 1'b0;
    step_in = 1'b0;
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    run_in = 1'b1;
    @(negedge Clock);
    applyStimulus({5'b00011, 4'd2, 4'd3, 4'd4, 15'd0}, 1'b0, 0, 1'b1);
    @(negedge Clock);
    Clear = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      #1;
      checkOutput("post_abort_idle", 32'(run), 32'h0);
    end

    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
